// File: rtl/matrix_stream_loader.sv
// matrix_stream_loader: collects 8-bit matrix elements from a valid/ready byte
// stream and assembles them into the packed A/B operand buses of the matrix
// multiplier. Packing is row-major, with element (0,0) in the most significant byte.
// A complete operand pair is presented with a level-held mat_valid. mat_valid
// stays high until the consumer returns mat_ack.
//
// Ports:
//   clk        clock, all state changes on the rising edge
//   rst        synchronous active-low reset
//   s_valid    upstream byte valid
//   s_data     upstream element (signed 8-bit, stored verbatim)
//   s_ready    loader can accept a byte this cycle (combinational)
//   abort      synchronous flush of the current load
//   a_out      packed matrix A
//   b_out      packed matrix B
//   mat_valid  a_out/b_out hold a complete operand pair
//   mat_ack    consumer has taken the pair
//   busy       part of a pair accepted, pair not yet complete (combinational)
//   dim_err    A_COLS != B_ROWS (static)
//
// Optional build macro MATLOAD_TRANSPOSE_B_EN: B bytes arrive column-major
// and are scattered into the row-major b_out.
module matrix_stream_loader #(
    parameter int unsigned A_ROWS = 2,
    parameter int unsigned A_COLS = 2,
    parameter int unsigned B_ROWS = 2,
    parameter int unsigned B_COLS = 2
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         s_valid,
    input  logic [7:0]                   s_data,
    output logic                         s_ready,
    input  logic                         abort,
    output logic [A_ROWS*A_COLS*8-1:0]   a_out,
    output logic [B_ROWS*B_COLS*8-1:0]   b_out,
    output logic                         mat_valid,
    input  logic                         mat_ack,
    output logic                         busy,
    output logic                         dim_err
);

    localparam int unsigned NA    = A_ROWS * A_COLS;
    localparam int unsigned NB    = B_ROWS * B_COLS;
    localparam int unsigned A_LEN = NA * 8;
    localparam int unsigned B_LEN = NB * 8;
    localparam int unsigned MAXN  = (NA > NB) ? NA : NB;
    localparam int unsigned CNT_W = (MAXN > 1) ? $clog2(MAXN) : 1;
    localparam logic        DIM_ERR = (A_COLS != B_ROWS);

    typedef enum logic [1:0] {LOAD_A, LOAD_B, HOLD} state_t;

    state_t             state, state_nxt;
    logic [CNT_W-1:0]   cnt, cnt_nxt;
    logic               mat_valid_nxt;
    logic [A_LEN-1:0]   a_nxt;
    logic [B_LEN-1:0]   b_nxt;
    logic               xfer;

`ifdef MATLOAD_TRANSPOSE_B_EN
    localparam int unsigned R_W = (B_ROWS > 1) ? $clog2(B_ROWS) : 1;
    localparam int unsigned C_W = (B_COLS > 1) ? $clog2(B_COLS) : 1;
    logic [R_W-1:0] r, r_nxt;
    logic [C_W-1:0] c, c_nxt;
`endif

    assign dim_err = DIM_ERR;
    assign s_ready = rst && !DIM_ERR && (state == LOAD_A || state == LOAD_B);
    assign xfer    = s_valid && s_ready;
    assign busy    = (state == LOAD_A && cnt != '0) || (state == LOAD_B);

    // State and datapath registers
    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= LOAD_A;
            cnt       <= '0;
            mat_valid <= 1'b0;
            a_out     <= '0;
            b_out     <= '0;
`ifdef MATLOAD_TRANSPOSE_B_EN
            r         <= '0;
            c         <= '0;
`endif
        end else begin
            state     <= state_nxt;
            cnt       <= cnt_nxt;
            mat_valid <= mat_valid_nxt;
            a_out     <= a_nxt;
            b_out     <= b_nxt;
`ifdef MATLOAD_TRANSPOSE_B_EN
            r         <= r_nxt;
            c         <= c_nxt;
`endif
        end
    end

    // Next-state, element placement and pair-valid logic
    always_comb begin
        state_nxt     = state;
        cnt_nxt       = cnt;
        mat_valid_nxt = mat_valid;
        a_nxt         = a_out;
        b_nxt         = b_out;
`ifdef MATLOAD_TRANSPOSE_B_EN
        r_nxt         = r;
        c_nxt         = c;
`endif
        if (abort) begin
            // Flush wins over any coincident transfer or ack; buses keep their bytes
            state_nxt     = LOAD_A;
            cnt_nxt       = '0;
            mat_valid_nxt = 1'b0;
`ifdef MATLOAD_TRANSPOSE_B_EN
            r_nxt         = '0;
            c_nxt         = '0;
`endif
        end else begin
            case (state)
                LOAD_A: begin
                    if (xfer) begin
                        for (int unsigned i = 0; i < NA; i++) begin
                            if (cnt == CNT_W'(i)) a_nxt[8*(NA-1-i) +: 8] = s_data;
                        end
                        if (cnt == CNT_W'(NA-1)) begin
                            state_nxt = LOAD_B;
                            cnt_nxt   = '0;
                        end else begin
                            cnt_nxt = cnt + CNT_W'(1);
                        end
                    end
                end
                LOAD_B: begin
                    if (xfer) begin
`ifdef MATLOAD_TRANSPOSE_B_EN
                        // Column-major arrival: row index runs fastest
                        for (int unsigned ri = 0; ri < B_ROWS; ri++) begin
                            for (int unsigned ci = 0; ci < B_COLS; ci++) begin
                                if (r == R_W'(ri) && c == C_W'(ci))
                                    b_nxt[8*(NB-1-(ri*B_COLS+ci)) +: 8] = s_data;
                            end
                        end
                        if (r == R_W'(B_ROWS-1)) begin
                            r_nxt = '0;
                            if (c == C_W'(B_COLS-1)) begin
                                c_nxt         = '0;
                                state_nxt     = HOLD;
                                mat_valid_nxt = 1'b1;
                            end else begin
                                c_nxt = c + C_W'(1);
                            end
                        end else begin
                            r_nxt = r + R_W'(1);
                        end
`else
                        for (int unsigned i = 0; i < NB; i++) begin
                            if (cnt == CNT_W'(i)) b_nxt[8*(NB-1-i) +: 8] = s_data;
                        end
                        if (cnt == CNT_W'(NB-1)) begin
                            state_nxt     = HOLD;
                            cnt_nxt       = '0;
                            mat_valid_nxt = 1'b1;
                        end else begin
                            cnt_nxt = cnt + CNT_W'(1);
                        end
`endif
                    end
                end
                HOLD: begin
                    if (mat_ack) begin
                        state_nxt     = LOAD_A;
                        mat_valid_nxt = 1'b0;
                    end
                end
                default: begin
                    state_nxt = LOAD_A;
                end
            endcase
        end
    end

endmodule
